// File: rtl/piso_tx_ctrl_pkg.sv
// Shared definitions for the piso_tx_ctrl serializer slice:
// controller state encoding and a constant-evaluable ceil(log2) helper.
package piso_tx_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Ceiling log2, usable in localparam expressions.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out shift register datapath. Load has priority over
// shift so a reload on the final beat of a word starts the next word cleanly.
module piso_shreg
   import piso_tx_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] din,
   output logic             sbit
);

   logic [WIDTH-1:0] r_sr;

   // Shift register: load a word, or move the next bit into the output slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr <= '0;
      end else if (load) begin
         r_sr <= din;
      end else if (shift_en) begin
         if (MSB_FIRST) r_sr <= {r_sr[WIDTH-2:0], 1'b0};
         else           r_sr <= {1'b0, r_sr[WIDTH-1:1]};
      end
   end

   assign sbit = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Handshaked serializer controller: accepts parallel words on a valid/ready
// input and emits them one bit per beat on a valid/ready serial port, with an
// optional forced idle gap between words or zero-bubble streaming when GAP=0.
module piso_tx_ctrl
   import piso_tx_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned GAP       = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din,
   input  logic             sout_ready,
   output logic             sout_valid,
   output logic             sout,
   output logic             sout_first,
   output logic             sout_last,
   output logic             busy
);

   localparam int unsigned    CW         = clog2(WIDTH);
   localparam int unsigned    GW         = (clog2(GAP + 1) < 1) ? 1 : clog2(GAP + 1);
   localparam logic [CW-1:0]  CNT_LAST   = CW'(WIDTH - 1);
   localparam logic [GW-1:0]  GAP_RELOAD = (GAP > 0) ? GW'(GAP - 1) : '0;
   localparam bit             BACK2BACK  = (GAP == 0);

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [GW-1:0]   r_gcnt, w_gcnt_nxt;
   logic            r_first, w_first_nxt;
   logic            w_accept, w_beat, w_cnt_zero, w_sbit;

   assign w_cnt_zero = (r_cnt == '0);
   assign in_ready   = !rst && ((r_state == ST_IDLE) ||
                       (BACK2BACK && (r_state == ST_SHIFT) && w_cnt_zero && sout_ready));
   assign sout_valid = (r_state == ST_SHIFT);
   assign sout       = sout_valid & w_sbit;
   assign sout_first = sout_valid & r_first;
   assign sout_last  = sout_valid & w_cnt_zero;
   assign busy       = (r_state != ST_IDLE);
   assign w_accept   = in_valid & in_ready;
   assign w_beat     = sout_valid & sout_ready;

   // Controller state, bit counter, gap counter and first-bit flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_gcnt  <= '0;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gcnt  <= w_gcnt_nxt;
         r_first <= w_first_nxt;
      end
   end

   // Next-state logic; counters hold when no beat so a stall freezes the bit.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gcnt_nxt  = r_gcnt;
      w_first_nxt = r_first;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_SHIFT;
               w_cnt_nxt   = CNT_LAST;
               w_first_nxt = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_beat) begin
               w_first_nxt = 1'b0;
               if (!w_cnt_zero) begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end else if (w_accept) begin
                  w_cnt_nxt   = CNT_LAST;
                  w_first_nxt = 1'b1;
               end else if (!BACK2BACK) begin
                  w_state_nxt = ST_GAP;
                  w_gcnt_nxt  = GAP_RELOAD;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (r_gcnt == '0) w_state_nxt = ST_IDLE;
            else              w_gcnt_nxt  = r_gcnt - 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   piso_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .load     (w_accept),
      .shift_en (w_beat),
      .din      (din),
      .sbit     (w_sbit)
   );

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: two instances (MSB-first/no gap, LSB-first/gap 2)
// share stimulus; each is compared every cycle against a word/bit-index model.
module tb_piso_tx_ctrl;

   localparam int W     = 4;
   localparam int MSB_A = 1;
   localparam int GAP_A = 0;
   localparam int MSB_B = 0;
   localparam int GAP_B = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  din = '0;
   logic          sout_ready = 1'b0;

   logic a_ir, a_sv, a_so, a_sf, a_sl, a_bz;
   logic b_ir, b_sv, b_so, b_sf, b_sl, b_bz;

   int n_vec = 0;
   int n_err = 0;

   // Model: word being sent, bits still to send, gap cycles still to spend.
   int m_word [2];
   int m_rem  [2];
   int m_gap  [2];

   always #5 clk = ~clk;

   piso_tx_ctrl #(.WIDTH(W), .MSB_FIRST(MSB_A), .GAP(GAP_A)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .din(din),
      .sout_ready(sout_ready), .sout_valid(a_sv), .sout(a_so),
      .sout_first(a_sf), .sout_last(a_sl), .busy(a_bz));

   piso_tx_ctrl #(.WIDTH(W), .MSB_FIRST(MSB_B), .GAP(GAP_B)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .din(din),
      .sout_ready(sout_ready), .sout_valid(b_sv), .sout(b_so),
      .sout_first(b_sf), .sout_last(b_sl), .busy(b_bz));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic int msb_of(input int k);
      return (k == 0) ? MSB_A : MSB_B;
   endfunction

   function automatic int gap_of(input int k);
      return (k == 0) ? GAP_A : GAP_B;
   endfunction

   function automatic logic m_valid(input int k);
      return m_rem[k] > 0;
   endfunction

   function automatic logic m_busy(input int k);
      return (m_rem[k] > 0) || (m_gap[k] > 0);
   endfunction

   function automatic logic m_bit(input int k);
      int idx, pos;
      if (m_rem[k] == 0) return 1'b0;
      idx = W - m_rem[k];
      pos = (msb_of(k) != 0) ? (W - 1 - idx) : idx;
      return 1'((m_word[k] >> pos) & 1);
   endfunction

   function automatic logic m_ready(input int k);
      if (rst) return 1'b0;
      return !m_busy(k) || (m_rem[k] == 1 && sout_ready && gap_of(k) == 0);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_word[k] = 0;
         m_rem[k]  = 0;
         m_gap[k]  = 0;
      end
   endtask

   task automatic cmp_all();
      logic [5:0] obs;
      for (int k = 0; k < 2; k++) begin
         obs = (k == 0) ? {a_ir, a_sv, a_so, a_sf, a_sl, a_bz}
                        : {b_ir, b_sv, b_so, b_sf, b_sl, b_bz};
         check_eq($sformatf("u%0d.in_ready", k),   32'(obs[5]), 32'(m_ready(k)));
         check_eq($sformatf("u%0d.sout_valid", k), 32'(obs[4]), 32'(m_valid(k)));
         check_eq($sformatf("u%0d.sout", k),       32'(obs[3]), 32'(m_bit(k)));
         check_eq($sformatf("u%0d.sout_first", k), 32'(obs[2]), 32'(m_rem[k] == W));
         check_eq($sformatf("u%0d.sout_last", k),  32'(obs[1]), 32'(m_rem[k] == 1));
         check_eq($sformatf("u%0d.busy", k),       32'(obs[0]), 32'(m_busy(k)));
      end
   endtask

   // One clock cycle: drive, check just after the falling edge, advance model.
   task automatic step(input logic iv, input logic [W-1:0] d, input logic sr);
      logic [1:0] acc, bt;
      @(negedge clk);
      in_valid   = iv;
      din        = d;
      sout_ready = sr;
      #1;
      cmp_all();
      for (int k = 0; k < 2; k++) begin
         acc[k] = iv && m_ready(k);
         bt[k]  = m_valid(k) && sr;
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (m_gap[k] > 0) m_gap[k]--;
         if (bt[k]) begin
            m_rem[k]--;
            if (m_rem[k] == 0 && gap_of(k) > 0) m_gap[k] = gap_of(k);
         end
         if (acc[k]) begin
            m_word[k] = int'(d);
            m_rem[k]  = W;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      model_clear();
      repeat (2) begin
         #1 cmp_all();
         @(negedge clk);
      end
      rst = 1'b0;
      #1 cmp_all();
   endtask

   // Reset asserted between clock edges; outputs must drop without a clock.
   task automatic mid_reset();
      #2;
      rst = 1'b1;
      in_valid = 1'b0;
      model_clear();
      #1 cmp_all();
      @(negedge clk);
      #1 cmp_all();
      @(negedge clk);
      rst = 1'b0;
      #1 cmp_all();
   endtask

   initial begin
      model_clear();
      do_reset();

      // Single word, free-running sink.
      step(1'b1, 4'b1100, 1'b1);
      repeat (6) step(1'b0, 4'b0000, 1'b1);

      // Same word with a 3-cycle stall on the second bit.
      step(1'b1, 4'b1100, 1'b1);
      step(1'b0, 4'b1111, 1'b1);
      repeat (3) step(1'b0, 4'b1111, 1'b0);
      repeat (6) step(1'b0, 4'b0000, 1'b1);

      // in_valid held: 1100 then 1010 streamed back to back.
      step(1'b1, 4'b1100, 1'b1);
      repeat (4) step(1'b1, 4'b1010, 1'b1);
      repeat (8) step(1'b0, 4'b0000, 1'b1);

      // 0001 offered continuously: gap behaviour on the LSB-first instance.
      repeat (14) step(1'b1, 4'b0001, 1'b1);
      repeat (6) step(1'b0, 4'b0000, 1'b1);

      // Reset after the second bit, then a clean word.
      step(1'b1, 4'b1100, 1'b1);
      repeat (2) step(1'b0, 4'b0000, 1'b1);
      mid_reset();
      step(1'b1, 4'b0110, 1'b1);
      repeat (6) step(1'b0, 4'b0000, 1'b1);

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 149) == 0) mid_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
